// File: rtl/cl_ocl_fifo_slv.sv
// cl_ocl_fifo_slv: OCL cfg_bus slave bridging host MMIO to a TX (host->fabric) and an RX (fabric->host) FIFO.
// Latency: a cfg_wr/cfg_rd strobe in cycle N is acked in N+1 with registered cfg_rdata; FIFO heads are visible the cycle after a push.
// Backpressure: cfg_bus is never stalled; a TX push when full is dropped with tx_ovf set. rx_ready_o deasserts while the RX FIFO is full.
//
// Ports:
//   clk, rst                  sole clock; asynchronous active-high reset
//   cfg_addr/wdata/wr/rd      cfg_bus request; only cfg_addr[7:2] selects a register
//   cfg_ack/rdata             one-cycle completion pulse with read data
//   tx_data_o/v_o/ready_i     TX FIFO head toward the fabric
//   rx_data_i/v_i/ready_o     fabric words into the RX FIFO
//
// Register map (byte offset): 0x00 TX_DATA (W, push), 0x04 TX_VACANCY (R), 0x08 RX_DATA (R, pop),
// 0x0C RX_COUNT (R), 0x10 STATUS (R/W1C: bit0 tx_ovf, bit1 rx_udf), 0x14 CTRL (W: bit0 flush, reads 0).
// Unmapped offsets read 0xDEAD_BEEF and ignore writes.

// Generic synchronous FIFO with occupancy count and a flush that overrides push/pop.
// Latency: a pushed word is visible at head_dat the cycle after the push edge.
// Backpressure: push is ignored when count==DEPTH, pop is ignored when count==0.
module cl_ocl_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [DATA_W-1:0]          push_dat,
    input  logic                       pop,
    input  logic                       flush,
    output logic [DATA_W-1:0]          head_dat,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     cnt;
    logic              push_ok;
    logic              pop_ok;

    // Full/empty are judged from the registered count, so a same-cycle pop never makes room for a push.
    assign push_ok  = push && (cnt != FULL_CNT);
    assign pop_ok   = pop && (cnt != '0);
    assign head_dat = mem[rd_ptr];
    assign count    = cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= push_dat;
    end
endmodule

module cl_ocl_fifo_slv #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       cfg_addr,
    input  logic [31:0]       cfg_wdata,
    input  logic              cfg_wr,
    input  logic              cfg_rd,
    output logic              cfg_ack,
    output logic [31:0]       cfg_rdata,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_v_o,
    input  logic              tx_ready_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_v_i,
    output logic              rx_ready_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [5:0] IDX_TX_DATA = 6'h00;
    localparam logic [5:0] IDX_TX_VAC  = 6'h01;
    localparam logic [5:0] IDX_RX_DATA = 6'h02;
    localparam logic [5:0] IDX_RX_CNT  = 6'h03;
    localparam logic [5:0] IDX_STATUS  = 6'h04;
    localparam logic [5:0] IDX_CTRL    = 6'h05;

    typedef enum logic {IDLE, ACK} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              strobe_acc;
    logic              wr_acc;
    logic              rd_acc;
    logic [5:0]        reg_idx;
    logic [31:0]       rdata_nxt;
    logic              unused_addr_bits;

    logic [DATA_W-1:0] tx_head;
    logic [CW-1:0]     tx_count;
    logic              tx_push;
    logic              tx_pop;
    logic [CW-1:0]     tx_vacancy;

    logic [DATA_W-1:0] rx_head;
    logic [CW-1:0]     rx_count;
    logic              rx_pop;
    logic              rx_empty;

    logic              flush;
    logic              status_w1c;
    logic              tx_ovf;
    logic              rx_udf;
    logic              tx_ovf_set;
    logic              rx_udf_set;

    assign reg_idx          = cfg_addr[7:2];
    assign unused_addr_bits = ^{cfg_addr[31:8], cfg_addr[1:0]};

    // Handshake FSM: a strobe is only taken in IDLE; the ACK cycle ignores any strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        strobe_acc = 1'b0;
        cfg_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_wr || cfg_rd) begin
                    strobe_acc = 1'b1;
                    state_nxt  = ACK;
                end
            end
            ACK: begin
                cfg_ack   = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A simultaneous write and read is treated as a write only.
    assign wr_acc = strobe_acc && cfg_wr;
    assign rd_acc = strobe_acc && cfg_rd && !cfg_wr;

    assign tx_push    = wr_acc && (reg_idx == IDX_TX_DATA);
    assign status_w1c = wr_acc && (reg_idx == IDX_STATUS);
    assign flush      = wr_acc && (reg_idx == IDX_CTRL) && cfg_wdata[0];
    assign rx_pop     = rd_acc && (reg_idx == IDX_RX_DATA);

    assign tx_pop     = tx_ready_i && tx_v_o;
    assign tx_vacancy = FULL_CNT - tx_count;
    assign rx_empty   = (rx_count == '0);

    assign tx_ovf_set = tx_push && (tx_count == FULL_CNT);
    assign rx_udf_set = rx_pop && rx_empty;

    cl_ocl_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tx_push),
        .push_dat (cfg_wdata),
        .pop      (tx_pop),
        .flush    (flush),
        .head_dat (tx_head),
        .count    (tx_count)
    );

    cl_ocl_sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rx_v_i),
        .push_dat (rx_data_i),
        .pop      (rx_pop),
        .flush    (flush),
        .head_dat (rx_head),
        .count    (rx_count)
    );

    assign tx_data_o  = tx_head;
    assign tx_v_o     = (tx_count != '0);
    assign rx_ready_o = (rx_count != FULL_CNT);

    // Read data reflects state sampled in the strobe cycle, before this edge's side effects.
    always_comb begin
        rdata_nxt = 32'hDEAD_BEEF;
        case (reg_idx)
            IDX_TX_DATA: rdata_nxt = '0;
            IDX_TX_VAC:  rdata_nxt = 32'(tx_vacancy);
            IDX_RX_DATA: rdata_nxt = rx_empty ? '0 : 32'(rx_head);
            IDX_RX_CNT:  rdata_nxt = 32'(rx_count);
            IDX_STATUS:  rdata_nxt = {30'd0, rx_udf, tx_ovf};
            IDX_CTRL:    rdata_nxt = '0;
            default:     rdata_nxt = 32'hDEAD_BEEF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_rdata <= '0;
        end else if (rd_acc) begin
            cfg_rdata <= rdata_nxt;
        end
    end

    // Sticky flags: a set event in the same cycle as a W1C keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_ovf <= 1'b0;
            rx_udf <= 1'b0;
        end else begin
            tx_ovf <= tx_ovf_set || (tx_ovf && !(status_w1c && cfg_wdata[0]));
            rx_udf <= rx_udf_set || (rx_udf && !(status_w1c && cfg_wdata[1]));
        end
    end
endmodule

// File: tb/tb_cl_ocl_fifo_slv.sv
module tb_cl_ocl_fifo_slv;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        cfg_ack;
    logic [31:0] cfg_rdata;
    logic [31:0] tx_data_o;
    logic        tx_v_o;
    logic        tx_ready_i;
    logic [31:0] rx_data_i;
    logic        rx_v_i;
    logic        rx_ready_o;

    int errors = 0;
    int checks = 0;

    // Scoreboard for cfg acks: one entry per issued transaction.
    bit          chk_q[$];
    logic [31:0] exp_q[$];
    string       name_q[$];
    // Expected words leaving the TX FIFO, in order.
    logic [31:0] tx_exp_q[$];

    cl_ocl_fifo_slv #(.DEPTH(16), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wr     (cfg_wr),
        .cfg_rd     (cfg_rd),
        .cfg_ack    (cfg_ack),
        .cfg_rdata  (cfg_rdata),
        .tx_data_o  (tx_data_o),
        .tx_v_o     (tx_v_o),
        .tx_ready_i (tx_ready_i),
        .rx_data_i  (rx_data_i),
        .rx_v_i     (rx_v_i),
        .rx_ready_o (rx_ready_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: compares every ack and every TX handshake against the queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (cfg_ack) begin
                if (chk_q.size() == 0) begin
                    check("stray_ack", 32'd1, 32'd0);
                end else begin
                    bit          c;
                    logic [31:0] e;
                    string       n;
                    c = chk_q.pop_front();
                    e = exp_q.pop_front();
                    n = name_q.pop_front();
                    if (c) check(n, cfg_rdata, e);
                end
            end
            if (tx_v_o && tx_ready_i) begin
                if (tx_exp_q.size() == 0) check("tx_extra_word", tx_data_o, 32'hFFFF_FFFF);
                else check("tx_word", tx_data_o, tx_exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic xact(input bit wr, input bit rd, input logic [31:0] addr, input logic [31:0] wdata,
                        input bit chk, input logic [31:0] exp, input string nm);
        chk_q.push_back(chk);
        exp_q.push_back(exp);
        name_q.push_back(nm);
        cfg_addr  = addr;
        cfg_wdata = wdata;
        cfg_wr    = wr;
        cfg_rd    = rd;
        @(posedge clk);
        #1;
        cfg_wr = 1'b0;
        cfg_rd = 1'b0;
        check({"ack_lat_", nm}, {31'd0, cfg_ack}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wr32(input logic [31:0] addr, input logic [31:0] wdata);
        xact(1'b1, 1'b0, addr, wdata, 1'b0, 32'd0, "wr");
    endtask

    task automatic rd32(input logic [31:0] addr, input logic [31:0] exp, input string nm);
        xact(1'b0, 1'b1, addr, 32'd0, 1'b1, exp, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        cfg_addr = '0; cfg_wdata = '0; cfg_wr = 1'b0; cfg_rd = 1'b0;
        tx_ready_i = 1'b0; rx_data_i = '0; rx_v_i = 1'b0;
        cyc(3);
        check("rst_ack", {31'd0, cfg_ack}, 32'd0);
        check("rst_rdata", cfg_rdata, 32'd0);
        check("rst_tx_v", {31'd0, tx_v_o}, 32'd0);
        check("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        rst = 1'b0;
        cyc(1);

        // Single TX word
        wr32(32'h00, 32'hA5A5_0001);
        check("tx_v_one", {31'd0, tx_v_o}, 32'd1);
        check("tx_head_one", tx_data_o, 32'hA5A5_0001);
        rd32(32'h04, 32'd15, "tx_vac_15");
        rd32(32'h0C, 32'd0, "rx_cnt_0");
        rd32(32'h10, 32'd0, "status_0");
        tx_exp_q.push_back(32'hA5A5_0001);
        tx_ready_i = 1'b1;
        cyc(1);
        tx_ready_i = 1'b0;
        check("tx_v_drained", {31'd0, tx_v_o}, 32'd0);

        // TX overflow: 17 writes, 16 kept
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_exp_q.push_back(32'h0000_0100 + i);
            wr32(32'h00, 32'h0000_0100 + i);
        end
        rd32(32'h04, 32'd0, "tx_vac_full");
        rd32(32'h10, 32'd1, "status_tx_ovf");
        tx_ready_i = 1'b1;
        for (int c = 0; c < 40; c++) begin
            cyc(1);
            if (!tx_v_o) break;
        end
        tx_ready_i = 1'b0;
        check("tx_drain_done", {31'd0, tx_v_o}, 32'd0);
        check("tx_words_left", tx_exp_q.size(), 32'd0);
        wr32(32'h10, 32'h1);
        rd32(32'h10, 32'd0, "status_w1c_ovf");

        // RX basic and underflow
        rx_v_i = 1'b1; rx_data_i = 32'h11;
        cyc(1);
        rx_data_i = 32'h22;
        cyc(1);
        rx_v_i = 1'b0;
        rd32(32'h0C, 32'd2, "rx_cnt_2");
        rd32(32'h08, 32'h11, "rx_pop_11");
        rd32(32'h08, 32'h22, "rx_pop_22");
        rd32(32'h08, 32'h0, "rx_pop_empty");
        rd32(32'h10, 32'd2, "status_rx_udf");
        // Write and read together: write wins, single ack; 0 to STATUS changes nothing
        xact(1'b1, 1'b1, 32'h10, 32'h0, 1'b0, 32'd0, "wr_rd_both");
        rd32(32'h10, 32'd2, "status_after_both");
        wr32(32'h10, 32'h2);
        rd32(32'h10, 32'd0, "status_w1c_udf");

        // RX full with fabric still offering a word
        for (int i = 0; i < 16; i++) begin
            rx_v_i = 1'b1;
            rx_data_i = 32'h200 + i;
            cyc(1);
        end
        rx_data_i = 32'h2FF;
        check("rx_ready_full", {31'd0, rx_ready_o}, 32'd0);
        rd32(32'h0C, 32'd16, "rx_cnt_16");
        chk_q.push_back(1'b1);
        exp_q.push_back(32'h200);
        name_q.push_back("rx_full_pop");
        cfg_addr = 32'h08;
        cfg_rd = 1'b1;
        cyc(1);
        cfg_rd = 1'b0;
        check("rx_ready_rise", {31'd0, rx_ready_o}, 32'd1);
        cyc(1);
        rx_v_i = 1'b0;
        check("rx_ready_refull", {31'd0, rx_ready_o}, 32'd0);
        rd32(32'h0C, 32'd16, "rx_cnt_refill");
        for (int i = 1; i < 16; i++) rd32(32'h08, 32'h200 + i, "rx_full_seq");
        rd32(32'h08, 32'h2FF, "rx_late_word");
        rd32(32'h0C, 32'd0, "rx_cnt_empty");

        // Flush with both FIFOs partially full
        for (int i = 0; i < 3; i++) wr32(32'h00, 32'h300 + i);
        rx_v_i = 1'b1; rx_data_i = 32'h400;
        cyc(2);
        rx_v_i = 1'b0;
        wr32(32'h14, 32'h1);
        rd32(32'h04, 32'd16, "flush_tx_vac");
        rd32(32'h0C, 32'd0, "flush_rx_cnt");
        check("flush_tx_v", {31'd0, tx_v_o}, 32'd0);
        check("flush_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        rd32(32'h14, 32'd0, "ctrl_reads_0");
        rd32(32'h40, 32'hDEAD_BEEF, "unmapped_40");
        rd32(32'h0000_0113, 32'd0, "alias_status");

        // Reset between strobe and ack
        rd32(32'h08, 32'h0, "rx_udf_again");
        rd32(32'h10, 32'd2, "status_pre_rst");
        cfg_addr = 32'h00; cfg_wdata = 32'hCAFE_0000; cfg_wr = 1'b1;
        cyc(1);
        cfg_wr = 1'b0;
        check("pre_rst_tx_v", {31'd0, tx_v_o}, 32'd1);
        rst = 1'b1;
        #1;
        check("rst_ack_suppressed", {31'd0, cfg_ack}, 32'd0);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        check("post_rst_tx_v", {31'd0, tx_v_o}, 32'd0);
        check("post_rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        rd32(32'h10, 32'd0, "post_rst_status");
        rd32(32'h04, 32'd16, "post_rst_tx_vac");

        cyc(3);
        check("ack_queue_drained", chk_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
